// File: rtl/misr_signature_collector.sv
// MISR signature collector: folds a valid-qualified word stream into one
// WIDTH-bit signature over WINDOW samples. Optional MISR_SAMPLE_CNT_EN build.
module misr_signature_collector #(
  parameter int                 WIDTH  = 32,
  parameter int                 WINDOW = 1024,
  parameter logic [WIDTH-1:0]   POLY   = WIDTH'(32'h04C11DB7),
  parameter logic [WIDTH-1:0]   SEED   = '1,
  localparam int                CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] sig_out,
  output logic             busy,
`ifdef MISR_SAMPLE_CNT_EN
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             drop_flag
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] sig_next;
  logic             last;

  // Next signature: shift with polynomial feedback, then fold in the word.
  always_comb begin
    sig_next = {sig_out[WIDTH-2:0], 1'b0}
             ^ (sig_out[WIDTH-1] ? POLY : '0)
             ^ in_data;
    cnt_inc  = cnt + 1'b1;
    last     = (cnt_inc == WIN);
  end

  // Window FSM; start outranks any sample, reset outranks everything.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      sig_out <= SEED;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      state   <= CAPTURE;
      sig_out <= SEED;
      cnt     <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (in_valid) begin
            sig_out <= sig_next;
            cnt     <= cnt_inc;
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        IDLE, DONE: ;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MISR_SAMPLE_CNT_EN
  assign sample_cnt = cnt;

  // Sticky flag for samples offered while no window is armed.
  always_ff @(posedge clk) begin
    if (!nrst || start) begin
      drop_flag <= 1'b0;
    end else if (in_valid && state != CAPTURE) begin
      drop_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_misr_signature_collector.sv
// Bench for misr_signature_collector: three 8-bit instances (WINDOW 2/4/1)
// and one default-parameter instance against a GF(2) polynomial model.
module tb_misr_signature_collector;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [31:0] in_data32;

  logic [7:0]  sig8  [3];
  logic        busy8 [3];
  logic        done8 [3];
  logic [7:0]  cnt8  [3];
  logic        drop8 [3];
  logic [31:0] sig32;
  logic        busy32;
  logic        done32;
  logic [10:0] cnt32;
  logic        drop32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g8
    localparam int WN = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
`ifdef MISR_SAMPLE_CNT_EN
    localparam int CW = $clog2(WN + 1);
    logic [CW-1:0] sc;
    assign cnt8[g] = 8'(sc);
`else
    assign cnt8[g]  = 8'd0;
    assign drop8[g] = 1'b0;
`endif
    misr_signature_collector #(
      .WIDTH(8), .WINDOW(WN), .POLY(8'h1D), .SEED(8'h00)
    ) u_dut (
      .clk(clk), .nrst(nrst), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .sig_out(sig8[g]), .busy(busy8[g]),
`ifdef MISR_SAMPLE_CNT_EN
      .done(done8[g]), .sample_cnt(sc), .drop_flag(drop8[g])
`else
      .done(done8[g])
`endif
    );
  end

`ifndef MISR_SAMPLE_CNT_EN
  assign cnt32  = 11'd0;
  assign drop32 = 1'b0;
`endif

  misr_signature_collector u_dut32 (
    .clk(clk), .nrst(nrst), .start(start),
    .in_valid(in_valid), .in_data(in_data32),
    .sig_out(sig32), .busy(busy32),
`ifdef MISR_SAMPLE_CNT_EN
    .done(done32), .sample_cnt(cnt32), .drop_flag(drop32)
`else
    .done(done32)
`endif
  );

  // Reference model: window bookkeeping plus the absorbed sample list.
  int          m_win  [4] = '{2, 4, 1, 1024};
  int          m_w    [4] = '{8, 8, 8, 32};
  logic [31:0] m_poly [4] = '{32'h1D, 32'h1D, 32'h1D, 32'h04C11DB7};
  logic [31:0] m_seed [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
  bit          m_arm  [4];
  bit          m_done [4];
  bit          m_drop [4];
  logic [31:0] m_q    [4][$];

  // Multiply by x modulo the polynomial.
  function automatic logic [31:0] mulx(logic [31:0] v, int k);
    logic [31:0] mask;
    logic        top;
    mask = (m_w[k] == 32) ? 32'hFFFFFFFF : ((32'd1 << m_w[k]) - 1);
    top  = v[m_w[k]-1];
    v    = (v << 1) & mask;
    if (top) v = v ^ m_poly[k];
    return v;
  endfunction

  function automatic logic [31:0] xpow(logic [31:0] v, int e, int k);
    for (int i = 0; i < e; i++) v = mulx(v, k);
    return v;
  endfunction

  // Signature = SEED*x^n + sum d_i*x^(n-1-i)  mod POLY.
  function automatic logic [31:0] msig(int k);
    int          n;
    logic [31:0] acc;
    n   = m_q[k].size();
    acc = xpow(m_seed[k], n, k);
    for (int i = 0; i < n; i++) acc = acc ^ xpow(m_q[k][i], n - 1 - i, k);
    return acc;
  endfunction

  task automatic model_step(input logic st, input logic v,
                            input logic [7:0] d, input logic [31:0] d32);
    for (int k = 0; k < 4; k++) begin
      if (!nrst) begin
        m_arm[k] = 0; m_done[k] = 0; m_drop[k] = 0; m_q[k].delete();
      end else if (st) begin
        m_arm[k] = 1; m_done[k] = 0; m_drop[k] = 0; m_q[k].delete();
      end else if (m_arm[k] && v) begin
        m_q[k].push_back((k == 3) ? d32 : {24'd0, d});
        if (m_q[k].size() == m_win[k]) begin
          m_arm[k] = 0; m_done[k] = 1;
        end
      end else if (v) begin
        m_drop[k] = 1;
      end
    end
  endtask

  task automatic cyc(input logic st, input logic v,
                     input logic [7:0] d, input logic [31:0] d32);
    start = st; in_valid = v; in_data = d; in_data32 = d32;
    @(posedge clk);
    model_step(st, v, d, d32);
    #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    cyc(1'b1, 1'b1, 8'hAB, 32'h1234);
    cyc(1'b0, 1'b1, 8'hCD, 32'h5678);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (sig8[k] !== 8'h00 || busy8[k] !== 1'b0 || done8[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset inst%0d: sig=%h busy=%b done=%b want 00/0/0",
                 k, sig8[k], busy8[k], done8[k]);
      end
`ifdef MISR_SAMPLE_CNT_EN
      n_cmp++;
      if (cnt8[k] !== 8'd0 || drop8[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_cnt inst%0d: cnt=%0d drop=%b want 0/0",
                 k, cnt8[k], drop8[k]);
      end
`endif
    end
    n_cmp++;
    if (sig32 !== 32'hFFFFFFFF || busy32 !== 1'b0 || done32 !== 1'b0) begin
      n_err++;
      $display("FAIL reset32: sig=%h busy=%b done=%b want ffffffff/0/0",
               sig32, busy32, done32);
    end
    nrst = 1'b1;
  endtask

  task automatic test_window2;
    cyc(1'b1, 1'b0, 8'h00, 32'h0);
    cyc(1'b0, 1'b1, 8'h01, 32'h0);
    n_cmp++;
    if (sig8[0] !== 8'h01 || done8[0] !== 1'b0 || busy8[0] !== 1'b1) begin
      n_err++;
      $display("FAIL w2_s1: sig=%h done=%b busy=%b want 01/0/1",
               sig8[0], done8[0], busy8[0]);
    end
    cyc(1'b0, 1'b1, 8'h02, 32'h0);
    n_cmp++;
    if (sig8[0] !== 8'h00 || done8[0] !== 1'b1 || busy8[0] !== 1'b0) begin
      n_err++;
      $display("FAIL w2_s2: sig=%h done=%b busy=%b want 00/1/0",
               sig8[0], done8[0], busy8[0]);
    end
  endtask

  task automatic test_gap;
    cyc(1'b1, 1'b0, 8'h00, 32'h0);
    cyc(1'b0, 1'b1, 8'h80, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'($urandom), $urandom);
      n_cmp++;
      if (sig8[0] !== 8'h80 || busy8[0] !== 1'b1) begin
        n_err++;
        $display("FAIL gap_hold%0d: sig=%h busy=%b want 80/1",
                 i, sig8[0], busy8[0]);
      end
    end
    cyc(1'b0, 1'b1, 8'h00, 32'h0);
    n_cmp++;
    if (sig8[0] !== 8'h1D || done8[0] !== 1'b1) begin
      n_err++;
      $display("FAIL gap_final: sig=%h done=%b want 1d/1",
               sig8[0], done8[0]);
    end
  endtask

  task automatic test_restart;
    cyc(1'b1, 1'b0, 8'h00, 32'h0);
    cyc(1'b0, 1'b1, 8'($urandom), $urandom);
    cyc(1'b0, 1'b1, 8'($urandom), $urandom);
    cyc(1'b1, 1'b1, 8'hAA, 32'hAAAA_AAAA);
    n_cmp++;
    if (sig8[1] !== 8'h00 || busy8[1] !== 1'b1 || done8[1] !== 1'b0) begin
      n_err++;
      $display("FAIL restart: sig=%h busy=%b done=%b want 00/1/0",
               sig8[1], busy8[1], done8[1]);
    end
`ifdef MISR_SAMPLE_CNT_EN
    n_cmp++;
    if (cnt8[1] !== 8'd0) begin
      n_err++;
      $display("FAIL restart_cnt: cnt=%0d want 0", cnt8[1]);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'($urandom), $urandom);
      n_cmp++;
      if (sig8[1] !== msig(1)[7:0] || done8[1] !== (i == 3)) begin
        n_err++;
        $display("FAIL restart_s%0d: sig=%h done=%b want %h/%b",
                 i, sig8[1], done8[1], msig(1)[7:0], (i == 3));
      end
    end
  endtask

  task automatic test_drop;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'hFF, 32'hFFFF_FFFF);
    n_cmp++;
    if (sig8[1] !== msig(1)[7:0] || done8[1] !== 1'b1 || m_q[1].size() != 4) begin
      n_err++;
      $display("FAIL drop_hold: sig=%h done=%b want %h/1",
               sig8[1], done8[1], msig(1)[7:0]);
    end
`ifdef MISR_SAMPLE_CNT_EN
    n_cmp++;
    if (drop8[1] !== 1'b1 || cnt8[1] !== 8'd4) begin
      n_err++;
      $display("FAIL drop_flag: drop=%b cnt=%0d want 1/4", drop8[1], cnt8[1]);
    end
`endif
  endtask

  task automatic test_window1;
    cyc(1'b1, 1'b0, 8'h00, 32'h0);
    cyc(1'b0, 1'b1, 8'h5A, 32'h0);
    n_cmp++;
    if (sig8[2] !== 8'h5A || done8[2] !== 1'b1 || busy8[2] !== 1'b0) begin
      n_err++;
      $display("FAIL w1: sig=%h done=%b busy=%b want 5a/1/0",
               sig8[2], done8[2], busy8[2]);
    end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'($urandom), $urandom);
    n_cmp++;
    if (sig32 !== msig(3) || busy32 !== 1'b1) begin
      n_err++;
      $display("FAIL mid32: sig=%h busy=%b want %h/1", sig32, busy32, msig(3));
    end
    nrst = 1'b0;
    cyc(1'b1, 1'b1, 8'($urandom), $urandom);
    nrst = 1'b1;
    n_cmp++;
    if (sig32 !== 32'hFFFFFFFF || busy32 !== 1'b0 || done32 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid32: sig=%h busy=%b done=%b want ffffffff/0/0",
               sig32, busy32, done32);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      nrst = ($urandom_range(0, 99) != 0);
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
          8'($urandom), $urandom);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (sig8[k] !== msig(k)[7:0] || busy8[k] !== m_arm[k]
            || done8[k] !== m_done[k]) begin
          n_err++;
          $display("FAIL rand c%0d inst%0d: sig=%h b=%b d=%b want %h/%b/%b",
                   c, k, sig8[k], busy8[k], done8[k],
                   msig(k)[7:0], m_arm[k], m_done[k]);
        end
`ifdef MISR_SAMPLE_CNT_EN
        n_cmp++;
        if (cnt8[k] !== 8'(m_q[k].size()) || drop8[k] !== m_drop[k]) begin
          n_err++;
          $display("FAIL rand_cnt c%0d inst%0d: cnt=%0d drop=%b want %0d/%b",
                   c, k, cnt8[k], drop8[k], m_q[k].size(), m_drop[k]);
        end
`endif
      end
      n_cmp++;
      if (sig32 !== msig(3) || busy32 !== m_arm[3] || done32 !== m_done[3]) begin
        n_err++;
        $display("FAIL rand32 c%0d: sig=%h b=%b d=%b want %h/%b/%b",
                 c, sig32, busy32, done32, msig(3), m_arm[3], m_done[3]);
      end
`ifdef MISR_SAMPLE_CNT_EN
      n_cmp++;
      if (cnt32 !== 11'(m_q[3].size()) || drop32 !== m_drop[3]) begin
        n_err++;
        $display("FAIL rand_cnt32 c%0d: cnt=%0d drop=%b want %0d/%b",
                 c, cnt32, drop32, m_q[3].size(), m_drop[3]);
      end
`endif
    end
    nrst = 1'b1;
  endtask

  initial begin
    nrst      = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_data32 = 32'h0;
    test_reset();
    test_window2();
    test_gap();
    test_restart();
    test_drop();
    test_window1();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
